gpio_csr: RTL and testbench

Parametrised CSR-mapped general-purpose I/O unit for the RISC-V core, replacing the fixed two-in/two-out I/O handling inside the CPU's writeback stage. Provides N_IN synchronised input channels, N_OUT registered output channels, sticky per-input change flags and a maskable interrupt. The core drives it from its CSR read (execute) and CSR write (writeback) paths. The default map keeps the existing addresses 0xF00–0xF03.

---
 rtl/gpio_csr_pkg.sv | 65 ++++++
 rtl/sync_ff.sv | 37 +++
 rtl/gpio_csr.sv | 177 +++++++++++++++++
 tb/tb_gpio_csr.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_csr_pkg.sv
// gpio_csr_pkg: shared constants, types and the CSR address decoder for gpio_csr.
//
// The CSR window starting at the base address is laid out as:
//   inputs (read-only), outputs (read/write), CHG (write-1-to-clear), MASK.
// The decoder turns a 12-bit address into {kind, index}. It is used by both
// the read path and the write path, so the two paths cannot disagree on the map.
package gpio_csr_pkg;

    localparam logic [11:0] DEFAULT_BASE = 12'hF00;

    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_IN   = 3'd1,
        K_OUT  = 3'd2,
        K_CHG  = 3'd3,
        K_MASK = 3'd4
    } csr_kind_e;

    typedef struct packed {
        csr_kind_e   kind;
        logic [11:0] index;
    } csr_dec_t;

    function automatic logic [11:0] off_in();
        return 12'd0;
    endfunction

    function automatic logic [11:0] off_out(input logic [11:0] n_in);
        return n_in;
    endfunction

    function automatic logic [11:0] off_chg(input logic [11:0] n_in, input logic [11:0] n_out);
        return n_in + n_out;
    endfunction

    function automatic logic [11:0] off_mask(input logic [11:0] n_in, input logic [11:0] n_out);
        return n_in + n_out + 12'd1;
    endfunction

    // Addresses below base wrap to a large offset and therefore decode as
    // unmapped, as long as the window fits inside the 12-bit CSR space.
    function automatic csr_dec_t csr_decode(input logic [11:0] addr,
                                            input logic [11:0] base,
                                            input logic [11:0] n_in,
                                            input logic [11:0] n_out);
        csr_dec_t    dec;
        logic [11:0] off;
        off       = addr - base;
        dec.kind  = K_NONE;
        dec.index = 12'd0;
        if (off < off_out(n_in)) begin
            dec.kind  = K_IN;
            dec.index = off - off_in();
        end else if (off < off_chg(n_in, n_out)) begin
            dec.kind  = K_OUT;
            dec.index = off - off_out(n_in);
        end else if (off == off_chg(n_in, n_out)) begin
            dec.kind  = K_CHG;
        end else if (off == off_mask(n_in, n_out)) begin
            dec.kind  = K_MASK;
        end
        return dec;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: WIDTH-bit, STAGES-deep flop-chain synchroniser with asynchronous
// active-low reset. All stages reset to 0.
//
// Ports:
//   clk    in  1      clock, rising edge
//   rst_n  in  1      asynchronous active-low reset
//   d      in  WIDTH  asynchronous input
//   q      out WIDTH  synchronised value (last stage)
module sync_ff #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    // Stage 0 captures the raw input; each later stage takes its predecessor.
    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_csr.sv
// gpio_csr: CSR-mapped general-purpose I/O unit.
//
// N_IN synchronised inputs, N_OUT registered outputs, a sticky per-input
// change flag register (CHG, write-1-to-clear) and an interrupt mask (MASK).
// irq is the OR of CHG & MASK and is combinational from registers only.
//
// Ports:
//   clk      in  1            clock, rising edge
//   rst_n    in  1            asynchronous active-low reset
//   io_in    in  N_IN*WIDTH   asynchronous inputs, channel i at [i*WIDTH +: WIDTH]
//   io_out   out N_OUT*WIDTH  output registers, same packing
//   rd_en    in  1            CSR read request
//   rd_addr  in  12           CSR read address
//   rd_data  out WIDTH        registered read data
//   rd_hit   out 1            registered: last read decoded to a valid CSR
//   wr_en    in  1            CSR write request
//   wr_addr  in  12           CSR write address
//   wr_data  in  WIDTH        CSR write data
//   wr_hit   out 1            combinational: wr_en and wr_addr is writable
//   irq      out 1            OR of (CHG & MASK)
//
// Request semantics: rd_en and wr_en are single-cycle requests that are
// always accepted on the edge that samples them; there is no ready/stall.
// A read result appears after that edge; a write takes effect on that edge.
// A read and write of the same CSR in one cycle returns the pre-write value.
module gpio_csr
    import gpio_csr_pkg::*;
#(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned N_OUT       = 2,
    parameter int unsigned WIDTH       = 32,
    parameter logic [11:0] BASE        = DEFAULT_BASE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN*WIDTH-1:0]  io_in,
    output logic [N_OUT*WIDTH-1:0] io_out,
    input  logic                   rd_en,
    input  logic [11:0]            rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_hit,
    input  logic                   wr_en,
    input  logic [11:0]            wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_hit,
    output logic                   irq
);

    localparam logic [11:0] NI = 12'(N_IN);
    localparam logic [11:0] NO = 12'(N_OUT);

    logic [N_IN-1:0][WIDTH-1:0]  s_ch;
    logic [N_IN-1:0][WIDTH-1:0]  prev_q, prev_d;
    logic [N_IN-1:0]             chg_q, chg_d;
    logic [N_IN-1:0]             mask_q, mask_d;
    logic [N_OUT-1:0][WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0]            rd_data_q, rd_data_d;
    logic                        rd_hit_q, rd_hit_d;

    logic [N_IN-1:0] chg_set;
    logic [N_IN-1:0] chg_clr;
    csr_dec_t        rd_dec;
    csr_dec_t        wr_dec;

    for (genvar g = 0; g < N_IN; g++) begin : g_sync
        sync_ff #(
            .WIDTH  (WIDTH),
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (io_in[g*WIDTH +: WIDTH]),
            .q     (s_ch[g])
        );
    end

    assign rd_dec = csr_decode(rd_addr, BASE, NI, NO);
    assign wr_dec = csr_decode(wr_addr, BASE, NI, NO);

    assign wr_hit = wr_en && ((wr_dec.kind == K_OUT) ||
                              (wr_dec.kind == K_CHG) ||
                              (wr_dec.kind == K_MASK));

    // Change detection and CHG update. A new change overrides a W1C clear
    // in the same cycle so no event is lost.
    always_comb begin
        prev_d  = s_ch;
        chg_set = '0;
        chg_clr = '0;
        for (int i = 0; i < N_IN; i++) begin
            chg_set[i] = (s_ch[i] != prev_q[i]);
        end
        if (wr_en && (wr_dec.kind == K_CHG)) begin
            chg_clr = wr_data[N_IN-1:0];
        end
        chg_d = (chg_q & ~chg_clr) | chg_set;
    end

    // Output and MASK writes. Mask bits above N_IN are simply not stored.
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        if (wr_en && (wr_dec.kind == K_OUT)) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (wr_dec.index == 12'(j)) begin
                    out_d[j] = wr_data;
                end
            end
        end
        if (wr_en && (wr_dec.kind == K_MASK)) begin
            mask_d = wr_data[N_IN-1:0];
        end
    end

    // Read path samples the current (pre-write) register values.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_hit_d  = 1'b0;
        if (rd_en) begin
            rd_data_d = '0;
            case (rd_dec.kind)
                K_IN: begin
                    rd_hit_d = 1'b1;
                    for (int i = 0; i < N_IN; i++) begin
                        if (rd_dec.index == 12'(i)) begin
                            rd_data_d = s_ch[i];
                        end
                    end
                end
                K_OUT: begin
                    rd_hit_d = 1'b1;
                    for (int j = 0; j < N_OUT; j++) begin
                        if (rd_dec.index == 12'(j)) begin
                            rd_data_d = out_q[j];
                        end
                    end
                end
                K_CHG: begin
                    rd_hit_d             = 1'b1;
                    rd_data_d[N_IN-1:0] = chg_q;
                end
                K_MASK: begin
                    rd_hit_d             = 1'b1;
                    rd_data_d[N_IN-1:0] = mask_q;
                end
                default: begin
                    rd_hit_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            chg_q     <= '0;
            mask_q    <= '0;
            out_q     <= '0;
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            chg_q     <= chg_d;
            mask_q    <= mask_d;
            out_q     <= out_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    assign io_out  = out_q;
    assign rd_data = rd_data_q;
    assign rd_hit  = rd_hit_q;
    assign irq     = |(chg_q & mask_q);

endmodule

// File: tb/tb_gpio_csr.sv
// tb_gpio_csr: directed self-checking bench for gpio_csr. Two instances:
// the default configuration and a N_IN=4, N_OUT=3, BASE=0x800 variant.
module tb_gpio_csr;

    logic        clk;
    logic        rst_n;
    logic [63:0] io_in;
    logic [63:0] io_out;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_hit;
    logic        irq;

    logic         rst_n2;
    logic [127:0] io_in2;
    logic [95:0]  io_out2;
    logic         rd_en2;
    logic [11:0]  rd_addr2;
    logic [31:0]  rd_data2;
    logic         rd_hit2;
    logic         wr_en2;
    logic [11:0]  wr_addr2;
    logic [31:0]  wr_data2;
    logic         wr_hit2;
    logic         irq2;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_csr dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_in   (io_in),
        .io_out  (io_out),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_hit  (rd_hit),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_hit  (wr_hit),
        .irq     (irq)
    );

    gpio_csr #(
        .N_IN  (4),
        .N_OUT (3),
        .BASE  (12'h800)
    ) dut2 (
        .clk     (clk),
        .rst_n   (rst_n2),
        .io_in   (io_in2),
        .io_out  (io_out2),
        .rd_en   (rd_en2),
        .rd_addr (rd_addr2),
        .rd_data (rd_data2),
        .rd_hit  (rd_hit2),
        .wr_en   (wr_en2),
        .wr_addr (wr_addr2),
        .wr_data (wr_data2),
        .wr_hit  (wr_hit2),
        .irq     (irq2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [11:0] addr);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic set_wr(input logic [11:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        #1;
    endtask

    task automatic do_read2(input logic [11:0] addr);
        rd_en2   = 1'b1;
        rd_addr2 = addr;
        tick();
        rd_en2   = 1'b0;
    endtask

    task automatic set_wr2(input logic [11:0] addr, input logic [31:0] data);
        wr_en2   = 1'b1;
        wr_addr2 = addr;
        wr_data2 = data;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n2 = 1'b0;
        io_in = '0; io_in2 = '0;
        rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_en2 = 0; rd_addr2 = '0; wr_en2 = 0; wr_addr2 = '0; wr_data2 = '0;
        #2;
        n_checks++; if (io_out !== 64'h0) begin n_fail++; $display("FAIL reset_io_out got %h want 0", io_out); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        n_checks++; if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd got hit=%b data=%h want 0/0", rd_hit, rd_data); end
        tick(); tick();
        rst_n = 1'b1; rst_n2 = 1'b1;
        tick();
        do_read(12'hF02);
        n_checks++; if (rd_data !== 32'h0 || rd_hit !== 1'b1) begin n_fail++; $display("FAIL read_out0_reset got data=%h hit=%b want 0/1", rd_data, rd_hit); end
        do_read(12'hF05);
        n_checks++; if (rd_data !== 32'h0 || rd_hit !== 1'b1) begin n_fail++; $display("FAIL read_mask_reset got data=%h hit=%b want 0/1", rd_data, rd_hit); end
        do_read(12'hF04);
        n_checks++; if (rd_data !== 32'h0 || rd_hit !== 1'b1) begin n_fail++; $display("FAIL read_chg_reset got data=%h hit=%b want 0/1", rd_data, rd_hit); end
    endtask

    task automatic test_write_out();
        set_wr(12'hF03, 32'hDEADBEEF);
        rd_en = 1'b1; rd_addr = 12'hF03;
        n_checks++; if (wr_hit !== 1'b1) begin n_fail++; $display("FAIL wr_hit_out1 got %b want 1", wr_hit); end
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (io_out[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL io_out1 got %h want deadbeef", io_out[63:32]); end
        n_checks++; if (rd_data !== 32'h0 || rd_hit !== 1'b1) begin n_fail++; $display("FAIL rd_same_cycle got data=%h hit=%b want 0/1", rd_data, rd_hit); end
        do_read(12'hF03);
        n_checks++; if (rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_out1 got %h want deadbeef", rd_data); end
        set_wr(12'hF02, 32'h12345678);
        tick();
        wr_en = 1'b0;
        n_checks++; if (io_out !== 64'hDEADBEEF_12345678) begin n_fail++; $display("FAIL io_out_both got %h want deadbeef12345678", io_out); end
    endtask

    task automatic test_input_chg();
        set_wr(12'hF05, 32'h1);
        tick();
        wr_en = 1'b0;
        io_in[31:0] = 32'h5;
        rd_en = 1'b1; rd_addr = 12'hF00;
        tick();
        n_checks++; if (rd_data !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL in_edge1 got data=%h irq=%b want 0/0", rd_data, irq); end
        tick();
        n_checks++; if (rd_data !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL in_edge2 got data=%h irq=%b want 0/0", rd_data, irq); end
        tick();
        rd_en = 1'b0;
        n_checks++; if (rd_data !== 32'h5) begin n_fail++; $display("FAIL in_edge3_data got %h want 5", rd_data); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL in_edge3_irq got %b want 1", irq); end
        do_read(12'hF04);
        n_checks++; if (rd_data !== 32'h1) begin n_fail++; $display("FAIL chg_after_in0 got %h want 1", rd_data); end
    endtask

    task automatic test_w1c();
        set_wr(12'hF04, 32'h1);
        n_checks++; if (wr_hit !== 1'b1) begin n_fail++; $display("FAIL wr_hit_chg got %b want 1", wr_hit); end
        tick();
        wr_en = 1'b0;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq got %b want 0", irq); end
        do_read(12'hF04);
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL w1c_chg got %h want 0", rd_data); end
        io_in[31:0] = 32'h6;
        tick(); tick();
        // change is now being detected; clear lands on the same edge
        set_wr(12'hF04, 32'h1);
        tick();
        wr_en = 1'b0;
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq got %b want 1", irq); end
        do_read(12'hF04);
        n_checks++; if (rd_data !== 32'h1) begin n_fail++; $display("FAIL set_wins_chg got %h want 1", rd_data); end
        set_wr(12'hF04, 32'h1);
        tick();
        wr_en = 1'b0;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c2_irq got %b want 0", irq); end
    endtask

    task automatic test_ignored();
        set_wr(12'hF00, 32'hFFFFFFFF);
        n_checks++; if (wr_hit !== 1'b0) begin n_fail++; $display("FAIL wr_hit_ro got %b want 0", wr_hit); end
        tick();
        set_wr(12'hF3A, 32'hFFFFFFFF);
        n_checks++; if (wr_hit !== 1'b0) begin n_fail++; $display("FAIL wr_hit_unmapped got %b want 0", wr_hit); end
        tick();
        wr_en = 1'b0;
        n_checks++; if (io_out !== 64'hDEADBEEF_12345678 || irq !== 1'b0) begin n_fail++; $display("FAIL ignored_state got io_out=%h irq=%b want deadbeef12345678/0", io_out, irq); end
        do_read(12'hF00);
        n_checks++; if (rd_data !== 32'h6) begin n_fail++; $display("FAIL rd_in0 got %h want 6", rd_data); end
        do_read(12'hF03);
        tick();
        n_checks++; if (rd_data !== 32'hDEADBEEF || rd_hit !== 1'b0) begin n_fail++; $display("FAIL rd_hold got data=%h hit=%b want deadbeef/0", rd_data, rd_hit); end
        do_read(12'hF3A);
        n_checks++; if (rd_data !== 32'h0 || rd_hit !== 1'b0) begin n_fail++; $display("FAIL rd_unmapped got data=%h hit=%b want 0/0", rd_data, rd_hit); end
        set_wr(12'hF05, 32'hFFFFFFFF);
        tick();
        wr_en = 1'b0;
        do_read(12'hF05);
        n_checks++; if (rd_data !== 32'h3 || rd_hit !== 1'b1) begin n_fail++; $display("FAIL mask_upper got data=%h hit=%b want 3/1", rd_data, rd_hit); end
    endtask

    task automatic test_input1();
        io_in[63:32] = 32'hA;
        tick(); tick(); tick();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL in1_irq got %b want 1", irq); end
        do_read(12'hF04);
        n_checks++; if (rd_data !== 32'h2) begin n_fail++; $display("FAIL in1_chg got %h want 2", rd_data); end
        do_read(12'hF01);
        n_checks++; if (rd_data !== 32'hA || rd_hit !== 1'b1) begin n_fail++; $display("FAIL in1_data got data=%h hit=%b want a/1", rd_data, rd_hit); end
    endtask

    task automatic test_variant();
        set_wr2(12'h804, 32'h11111111);
        n_checks++; if (wr_hit2 !== 1'b1) begin n_fail++; $display("FAIL v_wr_hit_804 got %b want 1", wr_hit2); end
        tick();
        set_wr2(12'h806, 32'h33333333);
        n_checks++; if (wr_hit2 !== 1'b1) begin n_fail++; $display("FAIL v_wr_hit_806 got %b want 1", wr_hit2); end
        tick();
        set_wr2(12'h803, 32'hFFFFFFFF);
        n_checks++; if (wr_hit2 !== 1'b0) begin n_fail++; $display("FAIL v_wr_hit_803 got %b want 0", wr_hit2); end
        tick();
        set_wr2(12'h809, 32'hFFFFFFFF);
        n_checks++; if (wr_hit2 !== 1'b0) begin n_fail++; $display("FAIL v_wr_hit_809 got %b want 0", wr_hit2); end
        tick();
        set_wr2(12'h808, 32'hFFFFFFFF);
        n_checks++; if (wr_hit2 !== 1'b1) begin n_fail++; $display("FAIL v_wr_hit_808 got %b want 1", wr_hit2); end
        tick();
        set_wr2(12'h807, 32'h0);
        n_checks++; if (wr_hit2 !== 1'b1) begin n_fail++; $display("FAIL v_wr_hit_807 got %b want 1", wr_hit2); end
        tick();
        wr_en2 = 1'b0;
        n_checks++; if (io_out2 !== 96'h33333333_00000000_11111111) begin n_fail++; $display("FAIL v_io_out got %h want 333333330000000011111111", io_out2); end
        do_read2(12'h808);
        n_checks++; if (rd_data2 !== 32'hF || rd_hit2 !== 1'b1) begin n_fail++; $display("FAIL v_mask got data=%h hit=%b want f/1", rd_data2, rd_hit2); end
        io_in2[127:96] = 32'h1;
        tick(); tick(); tick();
        n_checks++; if (irq2 !== 1'b1) begin n_fail++; $display("FAIL v_irq got %b want 1", irq2); end
        do_read2(12'h807);
        n_checks++; if (rd_data2 !== 32'h8) begin n_fail++; $display("FAIL v_chg got %h want 8", rd_data2); end
        // reset mid-write, between clock edges
        rd_en2 = 1'b1; rd_addr2 = 12'h806;
        set_wr2(12'h805, 32'h22222222);
        tick();
        #3;
        rst_n2 = 1'b0;
        #1;
        n_checks++; if (io_out2 !== 96'h0) begin n_fail++; $display("FAIL v_async_io_out got %h want 0", io_out2); end
        n_checks++; if (irq2 !== 1'b0 || rd_hit2 !== 1'b0 || rd_data2 !== 32'h0) begin n_fail++; $display("FAIL v_async_rest got irq=%b hit=%b data=%h want 0/0/0", irq2, rd_hit2, rd_data2); end
        wr_en2 = 1'b0; rd_en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_out();
        test_input_chg();
        test_w1c();
        test_ignored();
        test_input1();
        test_variant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
